// File: rtl/dmem_pkg.sv
// Shared types, default sizing and the byte-merge helper for the multi-port data memory.
package dmem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dmem_state_t;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DEPTH  = 16384;
    localparam int DMEM_NUM_RD = 2;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int DMEM_MAX_W  = 512;
    localparam int DMEM_MAX_BE = DMEM_MAX_W / 8;

    function automatic logic [DMEM_MAX_W-1:0] be_merge(
        input logic [DMEM_MAX_W-1:0]  old_word,
        input logic [DMEM_MAX_W-1:0]  new_word,
        input logic [DMEM_MAX_BE-1:0] be
    );
        logic [DMEM_MAX_W-1:0] merged;
        merged = old_word;
        for (int k = 0; k < DMEM_MAX_BE; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_clr_ctrl.sv
// Clear sequencer: walks every word writing zero after reset or a clear request,
// then holds READY until the next request.
module dmem_clr_ctrl
    import dmem_pkg::*;
#(
    parameter  int DEPTH  = DMEM_DEPTH,
    localparam int CPTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [CPTR_W-1:0] clr_addr,
    output logic              ready
);

    dmem_state_t       state_reg;
    logic [CPTR_W-1:0] cptr_reg;
    logic              ready_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            cptr_reg  <= '0;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    if (cptr_reg == CPTR_W'(DEPTH - 1)) begin
                        state_reg <= READY;
                        ready_reg <= 1'b1;
                        cptr_reg  <= '0;
                    end else begin
                        cptr_reg <= cptr_reg + 1'b1;
                    end
                end
                READY: begin
                    if (clr_req) begin
                        state_reg <= CLEAR;
                        ready_reg <= 1'b0;
                        cptr_reg  <= '0;
                    end
                end
                default: begin
                    state_reg <= CLEAR;
                    ready_reg <= 1'b0;
                    cptr_reg  <= '0;
                end
            endcase
        end
    end

    assign clr_we   = (state_reg == CLEAR);
    assign clr_addr = cptr_reg;
    assign ready    = ready_reg;

endmodule

// File: rtl/dmem_multiport.sv
// Word-addressed RAM with one byte-enabled write port and NUM_RD registered read
// ports, write-first bypass, range checking and a built-in clear sequencer.
module dmem_multiport
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int NUM_RD = DMEM_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    input  logic                     wren,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wbe,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rerr,
    output logic                     werr,
    output logic                     ready
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             clr_we;
    logic [IDX_W-1:0] clr_addr;

    dmem_clr_ctrl #(
        .DEPTH(DEPTH)
    ) u_clr_ctrl (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .clr_we  (clr_we),
        .clr_addr(clr_addr),
        .ready   (ready)
    );

    // Shared write port: the clear sequencer and user writes never overlap
    // because user writes require READY.
    logic              waddr_ok;
    logic              user_we;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;

    assign waddr_ok  = 64'(waddr) < 64'(DEPTH);
    assign user_we   = ready && !rst && !clr_req && wren && waddr_ok;
    assign mem_we    = clr_we || user_we;
    assign mem_idx   = clr_we ? clr_addr : waddr[IDX_W-1:0];
    assign mem_wdata = clr_we ? '0 : wdata;
    assign mem_be    = clr_we ? '1 : wbe;

    logic werr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            werr_reg <= 1'b0;
        end else begin
            werr_reg <= ready && !clr_req && wren && !waddr_ok;
        end
    end

    assign werr = werr_reg;

    logic [NUM_RD-1:0][IDX_W-1:0]       rd_idx;
    logic [NUM_RD-1:0][BE_W-1:0][7:0]   ram_q;

    // One byte-wide array per lane keeps byte enables as plain per-lane write enables.
    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] mem_b [DEPTH];

            always_ff @(posedge clk) begin
                if (mem_we && mem_be[gi]) begin
                    mem_b[mem_idx] <= mem_wdata[8*gi +: 8];
                end
            end

            always_ff @(posedge clk) begin
                for (int p = 0; p < NUM_RD; p++) begin
                    ram_q[p][gi] <= mem_b[rd_idx[p]];
                end
            end
        end
    endgenerate

    // The array read is read-first, so a same-address write is merged in after
    // the read register using the captured write data and enables.
    logic [DATA_W-1:0] wdata_byp_reg;
    logic [BE_W-1:0]   wbe_byp_reg;

    always_ff @(posedge clk) begin
        wdata_byp_reg <= wdata;
        wbe_byp_reg   <= wbe;
    end

    logic [NUM_RD-1:0] rd_ok;
    logic [NUM_RD-1:0] rd_hit;
    logic [NUM_RD-1:0] zero_reg;
    logic [NUM_RD-1:0] rerr_reg;
    logic [NUM_RD-1:0] hit_reg;

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] raddr_p;

            assign raddr_p    = raddr[gi*ADDR_W +: ADDR_W];
            assign rd_ok[gi]  = 64'(raddr_p) < 64'(DEPTH);
            assign rd_idx[gi] = rd_ok[gi] ? raddr_p[IDX_W-1:0] : '0;
            assign rd_hit[gi] = user_we && rd_ok[gi] && (raddr_p == waddr);

            always_ff @(posedge clk) begin
                if (rst) begin
                    zero_reg[gi] <= 1'b1;
                    rerr_reg[gi] <= 1'b0;
                    hit_reg[gi]  <= 1'b0;
                end else begin
                    zero_reg[gi] <= !ready || !rd_ok[gi];
                    rerr_reg[gi] <= ready && !rd_ok[gi];
                    hit_reg[gi]  <= rd_hit[gi];
                end
            end

            assign rdata[gi*DATA_W +: DATA_W] =
                zero_reg[gi] ? '0 :
                hit_reg[gi]  ? DATA_W'(be_merge(DMEM_MAX_W'(ram_q[gi]),
                                                DMEM_MAX_W'(wdata_byp_reg),
                                                DMEM_MAX_BE'(wbe_byp_reg))) :
                               ram_q[gi];
            assign rerr[gi] = rerr_reg[gi];
        end
    endgenerate

endmodule
